// File: rtl/conflict_judge_if.sv
// Purpose : handshake bundle between the input-FIFO heads, conflict_judge and conflict_handler.
// Latency : wires only; no storage.
// Backpressure: out_ready carries downstream stall into the judge; pop/fail are the grant side.
//   master: upstream side (drives req, tail, out_ready; observes grants)
//   slave : conflict_judge (consumes req, tail, out_ready; drives fail, pop, busy, timeout_err)
interface conflict_judge_if;
    logic [2:0] req;          // per-source head flit valid and routed here (bit0 x, bit1 y, bit2 local)
    logic [2:0] tail;         // per-source head flit is a tail; meaningful only with req
    logic       out_ready;    // downstream can take a flit this cycle
    logic [2:0] fail;         // one-hot select of the source transferred on the next edge
    logic [2:0] pop;          // FIFO pop strobes, identical to fail
    logic       busy;         // wormhole lock held
    logic       timeout_err;  // one-cycle pulse when a stalled lock is revoked

    modport master (
        output req, tail, out_ready,
        input  fail, pop, busy, timeout_err
    );

    modport slave (
        input  req, tail, out_ready,
        output fail, pop, busy, timeout_err
    );
endinterface

// File: rtl/conflict_judge.sv
// Purpose : round-robin output-channel arbiter with wormhole lock; picks one of x/y/local per cycle.
// Latency : fail/pop/busy combinational from state + inputs; flit reaches dout one clock after fail.
// Backpressure: out_ready=0 suppresses all grants; the lock and priority pointer are held unchanged.
// Ports   : clk, rst_n (synchronous, active-high despite the name), bus (conflict_judge_if.slave).
// Option  : JUDGE_TIMEOUT_EN adds the stalled-lock revocation (wait_cnt, TIMEOUT, TW, timeout_err);
//           without it the lock is held indefinitely and timeout_err is tied low.
module conflict_judge #(
    parameter int NSRC = 3
`ifdef JUDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    conflict_judge_if.slave bus
);

    typedef enum logic {IDLE, LOCK} st_t;

    st_t        st, st_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [2:0] grant;
    logic [1:0] cand [3];
    logic [1:0] win;
    logic       win_vld;

`ifdef JUDGE_TIMEOUT_EN
    logic [TW-1:0] wait_cnt, wait_nxt;
    logic          to_nxt, to_q;
`endif

    // Successor in the x -> y -> local -> x ring; encoding 3 never appears.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s >= 2'(NSRC - 1)) ? 2'd0 : s + 2'd1;
    endfunction

    // Round-robin scan: ptr first, then its two successors. Scanning from the
    // lowest priority upward lets the highest-priority requester overwrite.
    always_comb begin
        cand[0] = ptr;
        cand[1] = next_src(ptr);
        cand[2] = next_src(cand[1]);
        win_vld = 1'b0;
        win     = ptr;
        for (int k = 2; k >= 0; k--) begin
            if (bus.req[cand[k]]) begin
                win_vld = 1'b1;
                win     = cand[k];
            end
        end
    end

    always_comb begin
        st_nxt    = st;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        grant     = 3'b000;
`ifdef JUDGE_TIMEOUT_EN
        wait_nxt  = wait_cnt;
        to_nxt    = 1'b0;
`endif
        case (st)
            IDLE: begin
                if (bus.out_ready && win_vld) begin
                    grant[win] = 1'b1;
`ifdef JUDGE_TIMEOUT_EN
                    wait_nxt = '0;
`endif
                    // Single-flit packets never take the lock.
                    if (bus.tail[win]) begin
                        ptr_nxt = next_src(win);
                    end else begin
                        st_nxt    = LOCK;
                        owner_nxt = win;
                    end
                end
            end
            LOCK: begin
                // Only the owner is eligible; other requests wait for the tail.
                if (bus.req[owner] && bus.out_ready) begin
                    grant[owner] = 1'b1;
`ifdef JUDGE_TIMEOUT_EN
                    wait_nxt = '0;
`endif
                    if (bus.tail[owner]) begin
                        st_nxt  = IDLE;
                        ptr_nxt = next_src(owner);
                    end
                end
`ifdef JUDGE_TIMEOUT_EN
                // Only an empty owner FIFO counts as a stall; downstream
                // backpressure does not. The TIMEOUT-th empty cycle revokes.
                else if (!bus.req[owner]) begin
                    if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        st_nxt   = IDLE;
                        ptr_nxt  = next_src(owner);
                        wait_nxt = '0;
                        to_nxt   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
`endif
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            st    <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
        end else begin
            st    <= st_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef JUDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wait_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            to_q     <= to_nxt;
        end
    end

    assign bus.timeout_err = to_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Reset masks the grant immediately so no FIFO is popped mid-reset.
    assign bus.fail = rst_n ? 3'b000 : grant;
    assign bus.pop  = bus.fail;
    assign bus.busy = !rst_n && (st == LOCK);

endmodule

// File: tb/tb_conflict_judge.sv
module tb_conflict_judge;

    localparam int TMO = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    conflict_judge_if bus ();

    conflict_judge dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: abstract arbitration state kept as plain integers.
    bit m_valid = 0;
    bit m_lock;
    int m_own;
    int m_prio;
    int m_stall;
    bit m_to;

    always @(negedge clk) begin
        logic [2:0] efail;
        logic       ebusy;
        int         w;
        efail = 3'b000;
        w     = -1;
        if (!rst_n) begin
            if (!m_lock) begin
                if (bus.out_ready) begin
                    for (int k = 0; k < 3; k++) begin
                        int s;
                        s = (m_prio + k) % 3;
                        if (bus.req[s] && w < 0) w = s;
                    end
                end
                if (w >= 0) efail = 3'(1 << w);
            end else if (bus.req[m_own] && bus.out_ready) begin
                efail = 3'(1 << m_own);
            end
        end
        ebusy = !rst_n && m_lock;

        if (m_valid) begin
            chk("model fail", {29'd0, bus.fail}, {29'd0, efail});
            chk("model pop", {29'd0, bus.pop}, {29'd0, efail});
            chk("model busy", {31'd0, bus.busy}, {31'd0, ebusy});
            chk("model timeout_err", {31'd0, bus.timeout_err}, {31'd0, m_to});
        end

        // Advance to the state the coming posedge produces.
        m_to = 0;
        if (rst_n) begin
            m_valid = 1;
            m_lock  = 0;
            m_own   = 0;
            m_prio  = 0;
            m_stall = 0;
        end else if (!m_lock) begin
            if (w >= 0) begin
                m_stall = 0;
                if (bus.tail[w]) m_prio = (w + 1) % 3;
                else begin
                    m_lock = 1;
                    m_own  = w;
                end
            end
        end else if (efail != 3'b000) begin
            m_stall = 0;
            if (bus.tail[m_own]) begin
                m_lock = 0;
                m_prio = (m_own + 1) % 3;
            end
        end else if (!bus.req[m_own]) begin
            m_stall++;
`ifdef JUDGE_TIMEOUT_EN
            if (m_stall == TMO) begin
                m_lock  = 0;
                m_prio  = (m_own + 1) % 3;
                m_stall = 0;
                m_to    = 1;
            end
`endif
        end
    end

    task automatic drive(input logic r, input logic [2:0] rq, input logic [2:0] tl, input logic rdy);
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.req       = rq;
        bus.tail      = tl;
        bus.out_ready = rdy;
        @(negedge clk);
    endtask

    // Drive one cycle and pin fail/pop/busy against hand-computed literals.
    task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] tl, input logic rdy,
                        input logic [2:0] ef, input logic eb, input string nm);
        drive(r, rq, tl, rdy);
        chk({nm, " fail"}, {29'd0, bus.fail}, {29'd0, ef});
        chk({nm, " pop"}, {29'd0, bus.pop}, {29'd0, ef});
        chk({nm, " busy"}, {31'd0, bus.busy}, {31'd0, eb});
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b1;
        bus.req       = 3'b000;
        bus.tail      = 3'b000;
        bus.out_ready = 1'b0;

        step(1, 3'b000, 3'b000, 0, 3'b000, 0, "reset0");
        step(1, 3'b111, 3'b111, 1, 3'b000, 0, "reset1");
        chk("reset timeout_err", {31'd0, bus.timeout_err}, 32'd0);

        // Single-flit packets from all sources rotate x, y, local.
        step(0, 3'b111, 3'b111, 1, 3'b001, 0, "rr x");
        step(0, 3'b111, 3'b111, 1, 3'b010, 0, "rr y");
        step(0, 3'b111, 3'b111, 1, 3'b100, 0, "rr local");

        // Three-flit packet on x holds the lock against y.
        step(0, 3'b011, 3'b000, 1, 3'b001, 0, "pkt head");
        step(0, 3'b011, 3'b000, 1, 3'b001, 1, "pkt body");
        step(0, 3'b011, 3'b001, 1, 3'b001, 1, "pkt tail");
        step(0, 3'b011, 3'b000, 1, 3'b010, 0, "after pkt y");

        // Locked on y; downstream stalls four cycles.
        for (int i = 0; i < 4; i++) step(0, 3'b111, 3'b000, 0, 3'b000, 1, "stall");
        step(0, 3'b111, 3'b000, 1, 3'b010, 1, "resume y");
        step(0, 3'b111, 3'b010, 1, 3'b010, 1, "y tail");

        // Locked on local mid-packet, then reset.
        step(0, 3'b111, 3'b000, 1, 3'b100, 0, "local head");
        step(0, 3'b111, 3'b000, 1, 3'b100, 1, "local body");
        step(1, 3'b111, 3'b000, 1, 3'b000, 0, "mid reset");
        step(0, 3'b111, 3'b000, 0, 3'b000, 0, "idle no ready");
        step(0, 3'b000, 3'b000, 1, 3'b000, 0, "idle no req");
        step(0, 3'b111, 3'b000, 1, 3'b001, 0, "post reset x");
        step(0, 3'b111, 3'b001, 1, 3'b001, 1, "post reset x tail");

        // ptr=1 with all requesting grants y, then local.
        step(0, 3'b111, 3'b111, 1, 3'b010, 0, "all ptr1 y");
        step(0, 3'b111, 3'b111, 1, 3'b100, 0, "next local");

        // Lock on x, then the x FIFO runs dry.
        step(0, 3'b001, 3'b000, 1, 3'b001, 0, "lock x");
        for (int i = 0; i < 20; i++) begin
`ifdef JUDGE_TIMEOUT_EN
            step(0, 3'b000, 3'b000, 1, 3'b000, (i < TMO), "dry x");
            chk("dry timeout_err", {31'd0, bus.timeout_err}, (i == TMO) ? 32'd1 : 32'd0);
`else
            step(0, 3'b000, 3'b000, 1, 3'b000, 1, "dry x");
            chk("dry timeout_err", {31'd0, bus.timeout_err}, 32'd0);
`endif
        end
`ifdef JUDGE_TIMEOUT_EN
        step(0, 3'b011, 3'b000, 1, 3'b010, 0, "after revoke y");
        step(0, 3'b011, 3'b010, 1, 3'b010, 1, "after revoke y tail");
`else
        step(0, 3'b011, 3'b000, 1, 3'b001, 1, "lock kept x");
        step(0, 3'b011, 3'b001, 1, 3'b001, 1, "lock kept x tail");
`endif

        // Mixed traffic checked against the model only.
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 3'((i * 5 + 3) ^ (i >> 2)), 3'((i * 3) >> 1), (i % 5) != 0);
        end
        drive(1'b1, 3'b000, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 3'b000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
